// File: rtl/keypad_scanner_4x4.sv
// 4x4 matrix keypad scanner: rotates an active-low column drive, debounces whole-keypad
// snapshots and emits one pulse per clean single-key press, shifting codes into a 4-digit register.
module keypad_scanner_4x4 #(
    parameter int SCAN_TICKS     = 1350,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  row,
    output logic [3:0]  col,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic        key_held,
    output logic [15:0] digits
);

    localparam int TW = $clog2(SCAN_TICKS);
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_TICKS - 1);
    localparam logic [CW-1:0] CNT_MAX   = CW'(DEBOUNCE_SCANS);

    logic [3:0]    row_meta;
    logic [3:0]    row_sync;
    logic [TW-1:0] tick;
    logic [1:0]    idx;
    logic [15:0]   snapshot;
    logic [15:0]   previous;
    logic [15:0]   stable;
    logic [CW-1:0] deb_cnt;
    logic          stable_upd;
    logic          armed;

    logic          sample_now;
    logic [15:0]   snap_next;
    logic [CW-1:0] cnt_next;
    logic          first_reach;
    logic [4:0]    ones;
    logic [3:0]    code_sel;

    // Bit index is col*4+row; the table below maps it to the printed legend.
    function automatic logic [3:0] key_lut(input logic [3:0] bit_idx);
        case (bit_idx)
            4'd0:  key_lut = 4'h1;
            4'd1:  key_lut = 4'h4;
            4'd2:  key_lut = 4'h7;
            4'd3:  key_lut = 4'hE;
            4'd4:  key_lut = 4'h2;
            4'd5:  key_lut = 4'h5;
            4'd6:  key_lut = 4'h8;
            4'd7:  key_lut = 4'h0;
            4'd8:  key_lut = 4'h3;
            4'd9:  key_lut = 4'h6;
            4'd10: key_lut = 4'h9;
            4'd11: key_lut = 4'hF;
            4'd12: key_lut = 4'hA;
            4'd13: key_lut = 4'hB;
            4'd14: key_lut = 4'hC;
            default: key_lut = 4'hD;
        endcase
    endfunction

    always_comb begin
        sample_now = (tick == TICK_LAST);
        snap_next  = snapshot;
        snap_next[{idx, 2'b00} +: 4] = ~row_sync;
        if (snap_next == previous)
            cnt_next = (deb_cnt == CNT_MAX) ? deb_cnt : deb_cnt + CW'(1);
        else
            cnt_next = CW'(1);
        // A saturated count on an unchanged snapshot is not a new arrival.
        first_reach = (cnt_next == CNT_MAX) && !((snap_next == previous) && (deb_cnt == CNT_MAX));
    end

    always_comb begin
        ones     = '0;
        code_sel = '0;
        for (int i = 0; i < 16; i++) begin
            if (stable[i]) begin
                ones     = ones + 5'd1;
                code_sel = key_lut(4'(i));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_meta   <= 4'hF;
            row_sync   <= 4'hF;
            tick       <= '0;
            idx        <= '0;
            col        <= 4'b1110;
            snapshot   <= '0;
            previous   <= '0;
            stable     <= '0;
            deb_cnt    <= '0;
            stable_upd <= 1'b0;
        end else begin
            row_meta   <= row;
            row_sync   <= row_meta;
            stable_upd <= 1'b0;
            if (sample_now) begin
                tick     <= '0;
                idx      <= idx + 2'd1;
                col      <= ~(4'b0001 << (idx + 2'd1));
                snapshot <= snap_next;
                if (idx == 2'd3) begin
                    deb_cnt  <= cnt_next;
                    previous <= snap_next;
                    if (first_reach) begin
                        stable     <= snap_next;
                        stable_upd <= 1'b1;
                    end
                end
            end else begin
                tick <= tick + TW'(1);
            end
        end
    end

    // Decode only on a fresh debounced state, so a key held through reset stays disarmed.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_valid <= 1'b0;
            key_code  <= 4'h0;
            key_held  <= 1'b0;
            digits    <= 16'h0000;
            armed     <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (stable_upd) begin
                if (ones == 5'd0) begin
                    armed    <= 1'b1;
                    key_held <= 1'b0;
                end else if (ones == 5'd1) begin
                    key_held <= 1'b1;
                    if (armed) begin
                        key_valid <= 1'b1;
                        key_code  <= code_sel;
                        digits    <= {digits[11:0], code_sel};
                        armed     <= 1'b0;
                    end
                end else begin
                    key_held <= 1'b0;
                    armed    <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner_4x4.sv
// Bench for keypad_scanner_4x4: a key matrix modelled from the column drive, scenario tasks,
// and a key-level reference model (legend table + digit shift) with an expected queue.
module tb_keypad_scanner_4x4;

    localparam int ST   = 8;
    localparam int DS   = 3;
    localparam int SCAN = 4 * ST;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  row;
    logic [3:0]  col;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_held;
    logic [15:0] digits;

    logic [15:0] keys = '0;         // pressed switches, bit col*4+row
    logic [15:0] exp_digits = '0;
    logic [3:0]  exp_q[$];
    logic [3:0]  obs_q[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          n_pulse = 0;

    // Printed legend, indexed [row][col]
    logic [3:0] keymap [0:3][0:3] = '{'{4'h1, 4'h2, 4'h3, 4'hA},
                                      '{4'h4, 4'h5, 4'h6, 4'hB},
                                      '{4'h7, 4'h8, 4'h9, 4'hC},
                                      '{4'hE, 4'h0, 4'hF, 4'hD}};

    keypad_scanner_4x4 #(.SCAN_TICKS(ST), .DEBOUNCE_SCANS(DS)) dut (
        .clk(clk), .rst(rst), .row(row), .col(col), .key_valid(key_valid),
        .key_code(key_code), .key_held(key_held), .digits(digits)
    );

    always #5 clk = ~clk;

    // A pressed switch pulls its row low when its column is driven low.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[c*4+r] && !col[c]) row[r] = 1'b0;
    end

    always @(posedge clk) begin
        #1;
        if (key_valid) begin
            n_pulse++;
            obs_q.push_back(key_code);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_accept(input int r, input int c);
        exp_digits = {exp_digits[11:0], keymap[r][c]};
        exp_q.push_back(keymap[r][c]);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
        exp_digits = '0;
    endtask

    task automatic test_reset();
        logic [3:0] ec;
        @(negedge clk);
        rst  = 1'b1;
        keys = '0;
        cycles(2);
        n_cmp++; if (col !== 4'b1110) begin n_fail++; $display("FAIL reset_col got=%b want=1110", col); end
        n_cmp++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b want=0", key_valid); end
        n_cmp++; if (key_code !== 4'h0) begin n_fail++; $display("FAIL reset_code got=%h want=0", key_code); end
        n_cmp++; if (key_held !== 1'b0) begin n_fail++; $display("FAIL reset_held got=%b want=0", key_held); end
        n_cmp++; if (digits !== 16'h0000) begin n_fail++; $display("FAIL reset_digits got=%h want=0000", digits); end
        rst = 1'b0;
        exp_digits = '0;
        for (int k = 0; k < 8; k++) begin
            cycles(ST);
            ec = ~(4'b0001 << ((k + 1) % 4));
            n_cmp++; if (col !== ec) begin n_fail++; $display("FAIL col_rotate step=%0d got=%b want=%b", k, col, ec); end
        end
        cycles(2 * SCAN);
        n_cmp++; if (key_held !== 1'b0) begin n_fail++; $display("FAIL idle_held got=%b want=0", key_held); end
        n_cmp++; if (n_pulse !== 0) begin n_fail++; $display("FAIL idle_pulses got=%0d want=0", n_pulse); end
    endtask

    task automatic test_press5();
        int n0;
        int waited;
        n0 = n_pulse;
        waited = 0;
        keys[1*4+1] = 1'b1;
        while (n_pulse == n0 && waited < 4 * SCAN + 4) begin
            cycles(1);
            waited++;
        end
        n_cmp++; if (n_pulse == n0) begin n_fail++; $display("FAIL press5_latency waited=%0d limit=%0d no pulse", waited, 4 * SCAN + 4); end
        model_accept(1, 1);
        cycles(8 * SCAN - waited);
        n_cmp++; if (n_pulse !== n0 + 1) begin n_fail++; $display("FAIL press5_pulses got=%0d want=%0d", n_pulse - n0, 1); end
        n_cmp++; if (key_code !== exp_q[$]) begin n_fail++; $display("FAIL press5_code got=%h want=%h", key_code, exp_q[$]); end
        n_cmp++; if (digits !== exp_digits) begin n_fail++; $display("FAIL press5_digits got=%h want=%h", digits, exp_digits); end
        n_cmp++; if (key_held !== 1'b1) begin n_fail++; $display("FAIL press5_held got=%b want=1", key_held); end
        keys = '0;
        cycles(5 * SCAN);
        n_cmp++; if (key_held !== 1'b0) begin n_fail++; $display("FAIL press5_release_held got=%b want=0", key_held); end
        n_cmp++; if (n_pulse !== n0 + 1) begin n_fail++; $display("FAIL press5_no_repeat got=%0d want=1", n_pulse - n0); end
    endtask

    task automatic test_bounce();
        int n0;
        int guard;
        logic [3:0] pc;
        // Start toggling at a scan boundary so the sampled pattern never holds for DS scans.
        guard = 0;
        pc = col;
        cycles(1);
        while (!(pc == 4'b0111 && col == 4'b1110) && guard < 4 * SCAN) begin
            pc = col;
            cycles(1);
            guard++;
        end
        n_cmp++; if (guard >= 4 * SCAN) begin n_fail++; $display("FAIL bounce_align col=%b never wrapped", col); end
        n0 = n_pulse;
        for (int i = 0; i < 8; i++) begin
            keys[1*4+1] = (i % 2 == 0);
            cycles(20);
        end
        keys = '0;
        cycles(5 * SCAN);
        n_cmp++; if (n_pulse !== n0) begin n_fail++; $display("FAIL bounce_pulses got=%0d want=0", n_pulse - n0); end
        n_cmp++; if (digits !== exp_digits) begin n_fail++; $display("FAIL bounce_digits got=%h want=%h", digits, exp_digits); end
    endtask

    task automatic test_rollover();
        int n0;
        n0 = n_pulse;
        keys[0*4+0] = 1'b1;
        keys[1*4+0] = 1'b1;
        cycles(8 * SCAN);
        n_cmp++; if (n_pulse !== n0) begin n_fail++; $display("FAIL rollover_pulses got=%0d want=0", n_pulse - n0); end
        n_cmp++; if (key_held !== 1'b0) begin n_fail++; $display("FAIL rollover_held got=%b want=0", key_held); end
        keys = '0;
        cycles(5 * SCAN);
        keys[2*4+0] = 1'b1;
        cycles(6 * SCAN);
        model_accept(0, 2);
        n_cmp++; if (n_pulse !== n0 + 1) begin n_fail++; $display("FAIL after_rollover_pulses got=%0d want=1", n_pulse - n0); end
        n_cmp++; if (key_code !== exp_q[$]) begin n_fail++; $display("FAIL after_rollover_code got=%h want=%h", key_code, exp_q[$]); end
        n_cmp++; if (digits !== exp_digits) begin n_fail++; $display("FAIL after_rollover_digits got=%h want=%h", digits, exp_digits); end
        keys = '0;
        cycles(5 * SCAN);
    endtask

    task automatic test_sequence();
        int seq_r [5] = '{0, 0, 0, 3, 3};
        int seq_c [5] = '{0, 1, 2, 3, 2};
        seq_r[3] = 0;
        apply_reset();
        cycles(4 * SCAN);
        for (int i = 0; i < 5; i++) begin
            keys[seq_c[i]*4+seq_r[i]] = 1'b1;
            cycles(6 * SCAN);
            model_accept(seq_r[i], seq_c[i]);
            n_cmp++; if (digits !== exp_digits) begin n_fail++; $display("FAIL sequence_digits step=%0d got=%h want=%h", i, digits, exp_digits); end
            keys = '0;
            cycles(5 * SCAN);
        end
        n_cmp++; if (digits !== 16'h23AF) begin n_fail++; $display("FAIL sequence_final got=%h want=23af", digits); end
    endtask

    task automatic test_hold_through_reset();
        int n0;
        n0 = n_pulse;
        keys[2*4+3] = 1'b1;
        cycles($urandom_range(30, 50));
        apply_reset();
        cycles(8 * SCAN);
        n_cmp++; if (n_pulse !== n0) begin n_fail++; $display("FAIL held_reset_pulses got=%0d want=0", n_pulse - n0); end
        n_cmp++; if (key_held !== 1'b1) begin n_fail++; $display("FAIL held_reset_held got=%b want=1", key_held); end
        n_cmp++; if (digits !== exp_digits) begin n_fail++; $display("FAIL held_reset_digits got=%h want=%h", digits, exp_digits); end
        keys = '0;
        cycles(5 * SCAN);
        n_cmp++; if (key_held !== 1'b0) begin n_fail++; $display("FAIL held_reset_release got=%b want=0", key_held); end
        keys[2*4+3] = 1'b1;
        cycles(6 * SCAN);
        model_accept(3, 2);
        n_cmp++; if (n_pulse !== n0 + 1) begin n_fail++; $display("FAIL repress_pulses got=%0d want=1", n_pulse - n0); end
        n_cmp++; if (key_code !== exp_q[$]) begin n_fail++; $display("FAIL repress_code got=%h want=%h", key_code, exp_q[$]); end
        n_cmp++; if (digits !== exp_digits) begin n_fail++; $display("FAIL repress_digits got=%h want=%h", digits, exp_digits); end
        keys = '0;
        cycles(5 * SCAN);
    endtask

    task automatic test_random();
        int r;
        int c;
        obs_q.delete();
        exp_q.delete();
        for (int it = 0; it < 10; it++) begin
            r = $urandom_range(0, 3);
            c = $urandom_range(0, 3);
            keys[c*4+r] = 1'b1;
            cycles($urandom_range(5 * SCAN, 7 * SCAN));
            model_accept(r, c);
            n_cmp++; if (digits !== exp_digits) begin n_fail++; $display("FAIL random_digits it=%0d got=%h want=%h", it, digits, exp_digits); end
            n_cmp++; if (key_held !== 1'b1) begin n_fail++; $display("FAIL random_held it=%0d got=%b want=1", it, key_held); end
            keys = '0;
            cycles($urandom_range(5 * SCAN, 6 * SCAN));
        end
        n_cmp++; if (obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL random_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            n_cmp++; if (obs_q[0] !== exp_q[0]) begin n_fail++; $display("FAIL random_code got=%h want=%h", obs_q[0], exp_q[0]); end
            void'(obs_q.pop_front());
            void'(exp_q.pop_front());
        end
    endtask

    initial begin
        test_reset();
        test_press5();
        test_bounce();
        test_rollover();
        test_sequence();
        test_hold_through_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
